// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and defaults
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for instruction and PC-tag queues
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect flush and stale-response drain
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state, state_next;
  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding, out_next;
  logic [CW-1:0]     drop_count, drop_next;
  logic [CW-1:0]     occupancy, tag_count;
  logic              credit_ok, req_fire, rsp_ok, rsp_keep, q_pop;
  logic              q_empty, q_full, tag_empty, tag_full;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] q_head;

  assign imem_req_addr = pc;
  assign credit_ok = ({1'b0, occupancy} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign req_fire  = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_ok    = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep  = rsp_ok && (state == FETCH) && !redirect_en;
  assign out_valid = !rst && !q_empty && !redirect_en;
  assign q_pop     = out_valid && out_ready;
  assign out_instr = out_valid ? q_head[XLEN-1:0] : '0;
  assign out_pc    = out_valid ? q_head[2*XLEN-1:XLEN] : '0;

  always_comb begin
    out_next = outstanding;
    if (req_fire && !rsp_ok)      out_next = outstanding + CW'(1);
    else if (!req_fire && rsp_ok) out_next = outstanding - CW'(1);
  end

  always_comb begin
    state_next     = state;
    drop_next      = drop_count;
    imem_req_valid = !rst && (state == FETCH) && !redirect_en && credit_ok;
    if (redirect_en) begin
      drop_next  = out_next;
      state_next = (out_next != '0) ? DRAIN : FETCH;
    end else if (state == DRAIN && rsp_ok) begin
      drop_next = drop_count - CW'(1);
      if (drop_count == CW'(1)) state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= out_next;
      drop_count  <= drop_next;
      if (redirect_en)   pc <= redirect_pc & ~(XLEN'(3));
      else if (req_fire) pc <= pc + XLEN'(4);
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .flush(redirect_en),
    .push(req_fire), .push_data(pc),
    .pop(rsp_keep), .head(tag_head),
    .empty(tag_empty), .full(tag_full), .count(tag_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .flush(redirect_en),
    .push(rsp_keep), .push_data({tag_head, imem_rsp_data}),
    .pop(q_pop), .head(q_head),
    .empty(q_empty), .full(q_full), .count(occupancy)
  );

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && outstanding == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && q_full && !q_pop) && !(req_fire && tag_full));
  a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
    (state == FETCH) |-> (tag_count == outstanding && (!rsp_keep || !tag_empty)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_en, out_valid, out_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_instr, out_pc;

  int          total = 0, bad = 0, cyc = 0, lat = 1, pops = 0, p0 = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model returns in order once an entry's due cycle is reached.
  task automatic begin_cycle();
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic end_cycle();
    if (out_valid && out_ready) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n = 0;
    begin_cycle();
    while (!out_valid && n < 20) begin
      end_cycle();
      begin_cycle();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, out_pc, exp);
    end_cycle();
  endtask

  // Drains everything, then leaves exactly two requests in flight with 3-cycle latency.
  task automatic two_outstanding();
    imem_req_ready = 1'b0;
    run(4);
    lat = 3;
    imem_req_ready = 1'b1;
    run(2);
    lat = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
    redirect_en = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    run(1);
    begin_cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    end_cycle();

    // Startup and streaming with 1-cycle memory.
    rst = 1'b0; exp_pc = 32'h0;
    begin_cycle();
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk("c0_state", 32'(dut.state), 32'(FETCH));
    chk("c0_out_valid", 32'(out_valid), 32'd0);
    end_cycle();
    begin_cycle();
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_out_valid", 32'(out_valid), 32'd0);
    end_cycle();
    begin_cycle();
    chk("c2_out_valid", 32'(out_valid), 32'd1);
    chk("c2_out_pc", out_pc, 32'h0);
    chk("c2_out_instr", out_instr, 32'hA5A5_0000);
    end_cycle();
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", out_pc, 32'(4 * (i + 1)));
      end_cycle();
    end

    // Backpressure: queue fills to DEPTH, requests stop, nothing lost.
    out_ready = 1'b0;
    run(10);
    begin_cycle();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    end_cycle();
    out_ready = 1'b1; imem_req_ready = 1'b0; p0 = pops;
    run(6);
    chk("stall_queued", 32'(pops - p0), 32'd4);
    begin_cycle();
    chk("stall_empty", 32'(out_valid), 32'd0);
    end_cycle();
    imem_req_ready = 1'b1;
    run(6);

    // Redirect with two responses in flight.
    two_outstanding();
    redirect_en = 1'b1; redirect_pc = 32'h100;
    begin_cycle();
    chk("rd_out_valid", 32'(out_valid), 32'd0);
    chk("rd_req_valid", 32'(imem_req_valid), 32'd0);
    end_cycle();
    redirect_en = 1'b0; exp_pc = 32'h100;
    begin_cycle();
    chk("rd_drain1", 32'(dut.state), 32'(DRAIN));
    chk("rd_drain1_req", 32'(imem_req_valid), 32'd0);
    end_cycle();
    begin_cycle();
    chk("rd_drain2", 32'(dut.state), 32'(DRAIN));
    end_cycle();
    begin_cycle();
    chk("rd_fetch", 32'(dut.state), 32'(FETCH));
    chk("rd_req_valid2", 32'(imem_req_valid), 32'd1);
    chk("rd_req_addr", imem_req_addr, 32'h100);
    end_cycle();
    wait_out("rd_out_pc", 32'h100);
    run(4);

    // Unaligned redirect target is rounded down to a word.
    redirect_en = 1'b1; redirect_pc = 32'h203;
    begin_cycle();
    end_cycle();
    redirect_en = 1'b0; exp_pc = 32'h200;
    begin_cycle();
    chk("align_state", 32'(dut.state), 32'(FETCH));
    chk("align_req_addr", imem_req_addr, 32'h200);
    end_cycle();
    wait_out("align_out_pc", 32'h200);

    // Second redirect while draining replaces the target.
    two_outstanding();
    redirect_en = 1'b1; redirect_pc = 32'h180;
    begin_cycle();
    end_cycle();
    redirect_pc = 32'h300;
    begin_cycle();
    chk("dr_state_a", 32'(dut.state), 32'(DRAIN));
    end_cycle();
    redirect_en = 1'b0; exp_pc = 32'h300;
    begin_cycle();
    chk("dr_state_b", 32'(dut.state), 32'(DRAIN));
    end_cycle();
    begin_cycle();
    chk("dr_fetch", 32'(dut.state), 32'(FETCH));
    chk("dr_req_addr", imem_req_addr, 32'h300);
    end_cycle();
    wait_out("dr_out_pc", 32'h300);
    run(4);

    // Fetch PC wraps at the top of the address space.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    begin_cycle();
    end_cycle();
    redirect_en = 1'b0; exp_pc = 32'hFFFF_FFFC;
    begin_cycle();
    chk("wrap_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
    end_cycle();
    begin_cycle();
    chk("wrap_addr_lo", imem_req_addr, 32'h0);
    end_cycle();
    run(6);

    // Reset with a full queue.
    out_ready = 1'b0;
    run(10);
    begin_cycle();
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    end_cycle();
    rst = 1'b1;
    begin_cycle();
    chk("frst_out_valid", 32'(out_valid), 32'd0);
    chk("frst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("frst_out_pc", out_pc, 32'd0);
    end_cycle();
    rst = 1'b0; exp_pc = 32'h0; out_ready = 1'b1;
    begin_cycle();
    chk("frst_post_valid", 32'(out_valid), 32'd0);
    chk("frst_post_addr", imem_req_addr, 32'h0);
    chk("frst_post_req", 32'(imem_req_valid), 32'd1);
    end_cycle();
    wait_out("frst_out_pc", 32'h0);

    // Reset with three requests in flight.
    rst = 1'b1;
    run(1);
    rst = 1'b0; lat = 4; exp_pc = 32'h0;
    run(3);
    rst = 1'b1;
    begin_cycle();
    chk("orst_out_valid", 32'(out_valid), 32'd0);
    chk("orst_req_valid", 32'(imem_req_valid), 32'd0);
    end_cycle();
    rst = 1'b0; lat = 1; exp_pc = 32'h0;
    begin_cycle();
    chk("orst_post_addr", imem_req_addr, 32'h0);
    end_cycle();
    wait_out("orst_out_pc", 32'h0);
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
